// File: rtl/audio_pkg.sv
// Shared audio types and constants for the I2S output path.
// frame_clks/fs_hz give the frame period and sample rate for a divider/slot setting.
package audio_pkg;

   localparam int DEF_SAMPLE_W = 16;
   localparam int DEF_SLOT_W   = 32;
   localparam int DEF_CLK_DIV  = 8;

   typedef struct packed {
      logic [DEF_SAMPLE_W-1:0] l;
      logic [DEF_SAMPLE_W-1:0] r;
   } stereo_t;

   // One stereo frame is two slots of SLOT_W BCK periods, each 2*CLK_DIV clocks long.
   function automatic int frame_clks(input int clk_div, input int slot_w);
      return 4 * clk_div * slot_w;
   endfunction

   function automatic longint fs_hz(input longint f_clk, input int clk_div, input int slot_w);
      return f_clk / longint'(frame_clks(clk_div, slot_w));
   endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Small stereo-sample FIFO: valid/ready on the push side, pop strobe on the read side.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module audio_sample_fifo
   import audio_pkg::*;
#(
   parameter type T     = stereo_t,
   parameter int  DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push_valid,
   output logic push_ready,
   input  T     push_data,
   input  logic pop,
   output T     head,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   T            mem [DEPTH];
   logic        full;
   logic        do_push;
   logic        do_pop;

   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // Ready depends on pointer registers only, so a same-cycle pop never reaches it.
   assign push_ready = !full;
   assign do_push    = push_valid && !full;
   assign do_pop     = pop && !empty;
   assign head       = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips-timing I2S transmitter: buffered stereo PCM shifted out MSB first on a BCK
// divided down from clk_sys; the frame register repeats the last frame when starved.
module i2s_audio_tx
   import audio_pkg::*;
#(
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int SAMPLE_W   = DEF_SAMPLE_W,
   parameter int SLOT_W     = DEF_SLOT_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic                en,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [SAMPLE_W-1:0] s_left,
   input  logic [SAMPLE_W-1:0] s_right,
   output logic                i2s_bck,
   output logic                i2s_lrck,
   output logic                i2s_data,
   output logic                underrun
);

   localparam int DC_W = $clog2(CLK_DIV);
   localparam int P_W  = $clog2(SLOT_W);
   localparam int BC_W = P_W + 1;
   localparam logic [DC_W-1:0] DIV_LAST = DC_W'(CLK_DIV - 1);
   localparam logic [BC_W-1:0] BIT_LAST = BC_W'(2 * SLOT_W - 1);
   localparam logic [P_W-1:0]  POS_MSB  = P_W'(1);
   localparam logic [P_W-1:0]  POS_LSB  = P_W'(SAMPLE_W);

   typedef struct packed {
      logic [SAMPLE_W-1:0] l;
      logic [SAMPLE_W-1:0] r;
   } frame_t;

   frame_t              fifo_in;
   frame_t              fifo_head;
   frame_t              frame_q;
   logic                fifo_empty;
   logic [DC_W-1:0]     div_cnt;
   logic [BC_W-1:0]     bit_cnt;
   logic [BC_W-1:0]     bit_nxt;
   logic [P_W-1:0]      slot_pos;
   logic [SAMPLE_W-1:0] word;
   logic [SAMPLE_W-1:0] shifted;
   logic                div_wrap;
   logic                fall_evt;
   logic                frame_start;
   logic                pop_frame;
   logic                data_nxt;

   // Sample handshake: a frame transfers on a clk_sys edge where s_valid && s_ready;
   // s_left/s_right must be stable while s_valid is high, and offers while full are ignored.
   assign fifo_in = '{l: s_left, r: s_right};

   audio_sample_fifo #(
      .T     (frame_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk_sys),
      .rst_n      (reset_n),
      .push_valid (s_valid),
      .push_ready (s_ready),
      .push_data  (fifo_in),
      .pop        (pop_frame),
      .head       (fifo_head),
      .empty      (fifo_empty)
   );

   assign div_wrap    = (div_cnt == DIV_LAST);
   assign fall_evt    = en && div_wrap && i2s_bck;
   assign frame_start = fall_evt && (bit_cnt == BIT_LAST);
   assign pop_frame   = frame_start && !fifo_empty;
   assign bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BC_W'(1);
   assign slot_pos    = bit_nxt[P_W-1:0];

   // Position 0 of each slot carries the one-BCK I2S delay, so a frame loaded on the
   // same edge is never read before the next falling event.
   always_comb begin
      word     = bit_nxt[P_W] ? frame_q.r : frame_q.l;
      shifted  = word << (slot_pos - POS_MSB);
      data_nxt = 1'b0;
      if ((slot_pos >= POS_MSB) && (slot_pos <= POS_LSB)) data_nxt = shifted[SAMPLE_W-1];
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt  <= '0;
         bit_cnt  <= BIT_LAST;
         i2s_bck  <= 1'b0;
         i2s_lrck <= 1'b1;
         i2s_data <= 1'b0;
         underrun <= 1'b0;
      end else if (!en) begin
         div_cnt  <= '0;
         bit_cnt  <= BIT_LAST;
         i2s_bck  <= 1'b0;
         i2s_lrck <= 1'b1;
         i2s_data <= 1'b0;
         underrun <= 1'b0;
      end else begin
         underrun <= frame_start && fifo_empty;
         if (div_wrap) begin
            div_cnt <= '0;
            i2s_bck <= !i2s_bck;
         end else begin
            div_cnt <= div_cnt + DC_W'(1);
         end
         if (fall_evt) begin
            bit_cnt  <= bit_nxt;
            i2s_lrck <= bit_nxt[P_W];
            i2s_data <= data_nxt;
         end
      end
   end

   // The frame register is only replaced by a real pop; a starved frame start replays it.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) frame_q <= '0;
      else if (pop_frame) frame_q <= fifo_head;
   end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: a BCK-domain decoder rebuilds whole 64-bit frames,
// checked in order against hand-built expected frames.
module tb_i2s_audio_tx;

   localparam int FRAME        = 1024;
   localparam int EV_LRCK_FALL = 0;
   localparam int EV_UNDERRUN  = 1;
   localparam int EV_BCK_RISE  = 2;
   localparam int EV_RIGHT_ONE = 3;

   logic        clk_sys  = 1'b0;
   logic        reset_n  = 1'b0;
   logic        en       = 1'b0;
   logic        s_valid  = 1'b0;
   logic [15:0] s_left   = '0;
   logic [15:0] s_right  = '0;
   logic        s_ready;
   logic        i2s_bck;
   logic        i2s_lrck;
   logic        i2s_data;
   logic        underrun;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_q[$];
   logic [63:0] got_q[$];

   always #5 clk_sys = ~clk_sys;

   i2s_audio_tx dut (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .en       (en),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_left   (s_left),
      .s_right  (s_right),
      .i2s_bck  (i2s_bck),
      .i2s_lrck (i2s_lrck),
      .i2s_data (i2s_data),
      .underrun (underrun)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected line image of one frame, first transmitted bit in bit 63.
   function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
      return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
   endfunction

   // Receiver model: sample data on rising BCK, frame begins at the first rise after lrck 1->0.
   logic [63:0] mon_sh        = '0;
   int          mon_bits      = -1;
   logic        mon_prev_bck  = 1'b0;
   logic        mon_prev_lrck = 1'b1;

   always @(posedge clk_sys) begin
      #1;
      if (!reset_n || !en) begin
         mon_bits      = -1;
         mon_prev_bck  = 1'b0;
         mon_prev_lrck = 1'b1;
      end else begin
         if (i2s_bck && !mon_prev_bck) begin
            if (mon_prev_lrck && !i2s_lrck) mon_bits = 0;
            if (mon_bits >= 0) begin
               mon_sh[63 - mon_bits] = i2s_data;
               mon_bits++;
               if (mon_bits == 64) begin
                  got_q.push_back(mon_sh);
                  mon_bits = -1;
               end
            end
            mon_prev_lrck = i2s_lrck;
         end
         mon_prev_bck = i2s_bck;
      end
   end

   task automatic wait_evt(input string tag, input int kind, input int limit, output int n);
      logic prev_l;
      logic prev_b;
      logic hit;
      prev_l = i2s_lrck;
      prev_b = i2s_bck;
      hit    = 1'b0;
      n      = 0;
      while (!hit && n < limit) begin
         @(posedge clk_sys);
         #1;
         n++;
         case (kind)
            EV_LRCK_FALL: hit = prev_l && !i2s_lrck;
            EV_UNDERRUN:  hit = underrun;
            EV_BCK_RISE:  hit = !prev_b && i2s_bck;
            default:      hit = i2s_lrck && i2s_bck && i2s_data;
         endcase
         prev_l = i2s_lrck;
         prev_b = i2s_bck;
      end
      chk({tag, "_seen"}, 64'(hit), 64'd1);
   endtask

   task automatic push_one(input string tag, input logic [15:0] l, input logic [15:0] r);
      logic rdy;
      logic done;
      int   n;
      done = 1'b0;
      n    = 0;
      @(negedge clk_sys);
      s_valid = 1'b1;
      s_left  = l;
      s_right = r;
      while (!done && n < 4 * FRAME) begin
         rdy = s_ready;
         @(posedge clk_sys);
         n++;
         if (rdy) done = 1'b1;
         else @(negedge clk_sys);
      end
      #1 s_valid = 1'b0;
      chk({tag, "_accepted"}, 64'(done), 64'd1);
   endtask

   task automatic drain(input string tag, input int count);
      chk({tag, "_nframes"}, 64'(got_q.size()), 64'(count));
      while (got_q.size() > 0 && exp_q.size() > 0)
         chk({tag, "_frame"}, got_q.pop_front(), exp_q.pop_front());
      got_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   k;
      int   first_full;
      int   ur;
      int   viol;
      logic rdy;

      // Reset state
      repeat (3) @(posedge clk_sys);
      #1;
      chk("rst_bck", 64'(i2s_bck), 64'd0);
      chk("rst_lrck", 64'(i2s_lrck), 64'd1);
      chk("rst_data", 64'(i2s_data), 64'd0);
      chk("rst_underrun", 64'(underrun), 64'd0);
      chk("rst_ready", 64'(s_ready), 64'd1);

      // 1: idle stream after reset, underrun once per frame
      @(negedge clk_sys);
      reset_n = 1'b1;
      en      = 1'b1;
      wait_evt("t1_first", EV_LRCK_FALL, 100, n);
      chk("t1_first_lat", 64'(n), 64'd16);
      chk("t1_first_bck", 64'(i2s_bck), 64'd0);
      chk("t1_first_data", 64'(i2s_data), 64'd0);
      chk("t1_first_ur", 64'(underrun), 64'd1);
      @(posedge clk_sys);
      #1;
      chk("t1_ur_width", 64'(underrun), 64'd0);
      wait_evt("t1_ur_next", EV_UNDERRUN, 2 * FRAME, n);
      chk("t1_ur_period", 64'(n), 64'(FRAME - 1));
      wait_evt("t1_bck_a", EV_BCK_RISE, 64, n);
      wait_evt("t1_bck_b", EV_BCK_RISE, 64, n);
      chk("t1_bck_period", 64'(n), 64'd16);

      // 2: one sample, then repeated while starved
      wait_evt("t2_sync", EV_LRCK_FALL, 2 * FRAME, n);
      got_q.delete();
      exp_q.delete();
      exp_q.push_back(exp_frame(16'h0000, 16'h0000));
      push_one("t2_push", 16'hA5C3, 16'h8001);
      exp_q.push_back(exp_frame(16'hA5C3, 16'h8001));
      exp_q.push_back(exp_frame(16'hA5C3, 16'h8001));
      wait_evt("t2_f1", EV_LRCK_FALL, 2 * FRAME, n);
      chk("t2_pop_ur", 64'(underrun), 64'd0);
      wait_evt("t2_f2", EV_LRCK_FALL, 2 * FRAME, n);
      chk("t2_frame_period", 64'(n), 64'(FRAME));
      chk("t2_repeat_ur", 64'(underrun), 64'd1);
      wait_evt("t2_f3", EV_LRCK_FALL, 2 * FRAME, n);
      drain("t2", 3);

      // 3: continuous offer, FIFO fills to 4, one pop per frame
      wait_evt("t3_sync", EV_LRCK_FALL, 2 * FRAME, n);
      got_q.delete();
      exp_q.delete();
      exp_q.push_back(exp_frame(16'hA5C3, 16'h8001));
      k          = 0;
      first_full = -1;
      ur         = 0;
      for (int c = 0; c < 6 * FRAME + 10; c++) begin
         @(negedge clk_sys);
         s_valid = 1'b1;
         s_left  = 16'h1000 + 16'(k);
         s_right = 16'h2000 + 16'(k);
         rdy     = s_ready;
         if (!rdy && first_full < 0) first_full = k;
         @(posedge clk_sys);
         if (rdy) begin
            exp_q.push_back(exp_frame(s_left, s_right));
            k++;
         end
         #1;
         if (underrun) ur++;
      end
      s_valid = 1'b0;
      chk("t3_full_after", 64'(first_full), 64'd4);
      chk("t3_accepted", 64'(k), 64'd10);
      chk("t3_underruns", 64'(ur), 64'd0);
      drain("t3", 6);

      // 4: push exactly on a frame-start pop with three queued
      wait_evt("t4_sync", EV_LRCK_FALL, 2 * FRAME, n);
      for (int c = 1; c <= FRAME; c++) begin
         @(negedge clk_sys);
         s_valid = (c == FRAME);
         s_left  = 16'h3C3C;
         s_right = 16'hC3C3;
         @(posedge clk_sys);
      end
      #1 s_valid = 1'b0;
      chk("t4_edge_lrck", 64'(i2s_lrck), 64'd0);
      chk("t4_edge_ur", 64'(underrun), 64'd0);
      chk("t4_ready", 64'(s_ready), 64'd1);
      exp_q.push_back(exp_frame(16'h3C3C, 16'hC3C3));
      wait_evt("t4_empty", EV_UNDERRUN, 5 * FRAME, n);
      chk("t4_depth", 64'(n), 64'(4 * FRAME));
      drain("t4", 6);

      // 5: asynchronous reset in the right slot with the FIFO full
      push_one("t5_p0", 16'h1111, 16'h2222);
      push_one("t5_p1", 16'h3333, 16'h4444);
      push_one("t5_p2", 16'h5555, 16'h6666);
      push_one("t5_p3", 16'h7777, 16'h8888);
      chk("t5_full", 64'(s_ready), 64'd0);
      wait_evt("t5_right", EV_RIGHT_ONE, FRAME, n);
      #2 reset_n = 1'b0;
      #1;
      chk("t5_rst_bck", 64'(i2s_bck), 64'd0);
      chk("t5_rst_lrck", 64'(i2s_lrck), 64'd1);
      chk("t5_rst_data", 64'(i2s_data), 64'd0);
      chk("t5_rst_ready", 64'(s_ready), 64'd1);
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      reset_n = 1'b1;
      got_q.delete();
      exp_q.delete();
      chk("t5_ready_after", 64'(s_ready), 64'd1);
      wait_evt("t5_restart", EV_LRCK_FALL, 100, n);
      chk("t5_restart_lat", 64'(n), 64'd16);
      chk("t5_restart_ur", 64'(underrun), 64'd1);
      exp_q.push_back(exp_frame(16'h0000, 16'h0000));
      wait_evt("t5_next", EV_LRCK_FALL, 2 * FRAME, n);
      drain("t5", 1);

      // 6: en low with two frames queued, then resume
      push_one("t6_p0", 16'h1234, 16'hFEDC);
      push_one("t6_p1", 16'h0F0F, 16'hF0F0);
      repeat (300) @(posedge clk_sys);
      @(negedge clk_sys);
      en   = 1'b0;
      viol = 0;
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk_sys);
         #1;
         if (i2s_bck !== 1'b0 || i2s_lrck !== 1'b1 || i2s_data !== 1'b0 || underrun !== 1'b0)
            viol++;
      end
      chk("t6_idle", 64'(viol), 64'd0);
      chk("t6_ready", 64'(s_ready), 64'd1);
      got_q.delete();
      exp_q.delete();
      @(negedge clk_sys);
      en = 1'b1;
      wait_evt("t6_resume", EV_LRCK_FALL, 100, n);
      chk("t6_resume_lat", 64'(n), 64'd16);
      chk("t6_resume_ur", 64'(underrun), 64'd0);
      exp_q.push_back(exp_frame(16'h1234, 16'hFEDC));
      exp_q.push_back(exp_frame(16'h0F0F, 16'hF0F0));
      wait_evt("t6_f1", EV_LRCK_FALL, 2 * FRAME, n);
      chk("t6_second_ur", 64'(underrun), 64'd0);
      wait_evt("t6_f2", EV_LRCK_FALL, 2 * FRAME, n);
      chk("t6_starved_ur", 64'(underrun), 64'd1);
      drain("t6", 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
